// File: rtl/gdp_arb_if.sv
// Request/packer bundle between K requesting channels, the gdp_arb sequencer
// and the gdp packer it feeds.
interface gdp_arb_if #(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int LOG2K = 2
);
    logic [K-1:0]     req_valid;
    logic [K*N-1:0]   req_data;
    logic [K-1:0]     req_last;
    logic [K-1:0]     req_ready;
    logic [N-1:0]     pk_din;
    logic             pk_valid_din;
    logic             pk_flush;
    logic [LOG2K-1:0] pk_chan;
    logic             busy;

    modport master (
        output req_valid, req_data, req_last,
        input  req_ready, pk_din, pk_valid_din, pk_flush, pk_chan, busy
    );

    modport slave (
        input  req_valid, req_data, req_last,
        output req_ready, pk_din, pk_valid_din, pk_flush, pk_chan, busy
    );
endinterface

// File: rtl/gdp_arb.sv
// Round-robin arbiter that shares one gdp packer between K channels, holding
// each grant on word boundaries and tagging packed words with the channel id.
module gdp_arb #(
    parameter int N     = 8,
    parameter int M     = 4,
    parameter int LOG2M = 2,
    parameter int K     = 4,
    parameter int LOG2K = 2,
    parameter int BURST = 2,
    parameter int LOG2B = 1
) (
    input  logic      clk,
    input  logic      reset,
    gdp_arb_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [LOG2K-1:0] r_gnt;
    logic [LOG2K-1:0] r_ptr;
    logic [LOG2M-1:0] r_beat;
    logic [LOG2B-1:0] r_words;
    logic [K-1:0]     r_ready;
    logic             r_busy;

    logic             w_any;
    logic [LOG2K-1:0] w_pick;
    logic [K-1:0]     w_pick_oh;
    logic             w_acc;
    logic             w_last;
    logic             w_word_end;
    logic             w_release;

    // First requester strictly after r_ptr, wrapping modulo K.
    always_comb begin
        w_any     = 1'b0;
        w_pick    = '0;
        for (int unsigned i = 1; i <= K; i++) begin
            int unsigned idx;
            idx = (int'(r_ptr) + i) % K;
            if (!w_any && bus.req_valid[idx]) begin
                w_any  = 1'b1;
                w_pick = LOG2K'(idx);
            end
        end
        w_pick_oh = '0;
        w_pick_oh[w_pick] = 1'b1;
    end

    always_comb begin
        w_acc      = (r_state == BUSY) && bus.req_valid[r_gnt];
        w_last     = bus.req_last[r_gnt];
        w_word_end = w_acc && (w_last || (r_beat == LOG2M'(M - 1)));
        w_release  = w_word_end && (w_last || (r_words == LOG2B'(BURST - 1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= LOG2K'(K - 1);
            r_beat  <= '0;
            r_words <= '0;
            r_ready <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_ready <= w_pick_oh;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_acc) begin
                        if (w_word_end) begin
                            r_beat <= '0;
                            if (w_release) begin
                                r_ptr   <= r_gnt;
                                r_words <= '0;
                                r_ready <= '0;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_words <= r_words + 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Beat path to gdp is combinational so the packer sees zero added latency.
    assign bus.pk_din       = bus.req_data[N*int'(r_gnt) +: N];
    assign bus.pk_valid_din = w_acc;
    assign bus.pk_flush     = w_acc && w_last;
    assign bus.pk_chan      = r_gnt;
    assign bus.req_ready    = r_ready;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_gdp_arb.sv
// Scoreboard bench for gdp_arb: per-channel beat queues feed a transaction-level
// grant/word model; a negedge monitor checks every accepted beat and the bubble.
module tb_gdp_arb;
    localparam int N     = 8;
    localparam int M     = 4;
    localparam int LOG2M = 2;
    localparam int K     = 4;
    localparam int LOG2K = 2;
    localparam int BURST = 2;
    localparam int LOG2B = 1;

    typedef struct {
        logic [N-1:0] d;
        logic         last;
    } beat_t;

    typedef struct {
        int           chan;
        logic [N-1:0] d;
        logic         flush;
        logic         rel;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gdp_arb_if #(.N(N), .K(K), .LOG2K(LOG2K)) bus ();

    gdp_arb #(
        .N(N), .M(M), .LOG2M(LOG2M), .K(K), .LOG2K(LOG2K),
        .BURST(BURST), .LOG2B(LOG2B)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    beat_t chq[K][$];
    exp_t  exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    m_ptr  = K - 1;
    bit    mon_en = 0;
    bit    stall_en = 0;
    bit    rel_pend = 0;
    bit    idle_req = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Grant order and word splitting derived from the queued traffic alone.
    task automatic predict();
        beat_t mq[K][$];
        for (int c = 0; c < K; c++) mq[c] = chq[c];
        forever begin
            int g;
            int beat;
            int words;
            bit done;
            g = -1;
            for (int i = 1; i <= K; i++) begin
                int c;
                c = (m_ptr + i) % K;
                if (g < 0 && mq[c].size() > 0) g = c;
            end
            if (g < 0) break;
            beat = 0; words = 0; done = 0;
            while (!done && mq[g].size() > 0) begin
                beat_t b;
                bit we, rel;
                b   = mq[g].pop_front();
                we  = b.last || (beat == M - 1);
                rel = we && (b.last || (words == BURST - 1));
                exp_q.push_back('{g, b.d, b.last, rel});
                if (rel) done = 1;
                else if (we) begin words++; beat = 0; end
                else beat++;
            end
            m_ptr = g;
        end
    endtask

    task automatic drive();
        for (int c = 0; c < K; c++) begin
            bit st;
            st = stall_en && bus.req_ready[c] && ($urandom_range(0, 3) == 0);
            if (chq[c].size() > 0 && !st) begin
                bus.req_valid[c]        = 1'b1;
                bus.req_data[c*N +: N]  = chq[c][0].d;
                bus.req_last[c]         = chq[c][0].last;
            end else begin
                bus.req_valid[c]        = 1'b0;
                bus.req_data[c*N +: N]  = N'($urandom);
                bus.req_last[c]         = 1'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        reset  = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_ptr = K - 1;
    endtask

    task automatic run_phase(input int unsigned maxc);
        logic [K-1:0] acc;
        int unsigned  n;
        bit           pending;
        n = 0;
        predict();
        drive();
        mon_en = 1;
        pending = 1;
        while (pending && n < maxc) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int c = 0; c < K; c++)
                if (acc[c]) void'(chq[c].pop_front());
            drive();
            n++;
            pending = exp_q.size() > 0;
            for (int c = 0; c < K; c++) if (chq[c].size() > 0) pending = 1;
        end
        repeat (2) @(negedge clk);
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout: got %0d cycles expected < %0d, %0d beats undelivered",
                     n, maxc, exp_q.size());
            exp_q.delete();
            for (int c = 0; c < K; c++) chq[c].delete();
            do_reset();
        end
        mon_en = 0;
    endtask

    task automatic load(input int c, input int nbeats, input logic [N-1:0] base,
                        input bit last_at_end);
        for (int i = 0; i < nbeats; i++)
            chq[c].push_back('{base + N'(i), last_at_end && (i == nbeats - 1)});
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                rel_pend = 0;
                idle_req = 0;
            end else begin
                if (rel_pend) begin
                    check("bubble_busy", bus.busy, 0);
                    check("bubble_ready", bus.req_ready, 0);
                end else if (idle_req) begin
                    check("grant_after_one_bubble", bus.busy, 1);
                end
                rel_pend = 0;
                if (bus.busy) begin
                    logic [K-1:0] oh;
                    oh = '0;
                    oh[bus.pk_chan] = 1'b1;
                    check("ready_onehot", bus.req_ready, oh);
                end else begin
                    check("idle_valid_din", bus.pk_valid_din, 0);
                end
                if (bus.pk_valid_din) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got chan %0d data 0x%0h expected no beat",
                                 bus.pk_chan, bus.pk_din);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("pk_chan", bus.pk_chan, e.chan);
                        check("pk_din", bus.pk_din, e.d);
                        check("pk_flush", bus.pk_flush, e.flush);
                        rel_pend = e.rel;
                    end
                end else begin
                    check("flush_without_valid", bus.pk_flush, 0);
                end
                idle_req = !bus.busy && (bus.req_valid != '0);
            end
        end
    end

    initial begin : stim
        int unsigned n;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        do_reset();

        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 0);
        check("rst_valid_din", bus.pk_valid_din, 0);
        check("rst_flush", bus.pk_flush, 0);
        check("rst_chan", bus.pk_chan, 0);

        // all channels busy: expect rotation 0,1,2,3,0...
        for (int c = 0; c < K; c++) load(c, 12, N'(8'h20 + 8'(c * 16)), 1);
        run_phase(2000);

        load(2, 8, 8'h10, 0);
        run_phase(200);

        chq[1].push_back('{8'hA0, 1'b0});
        chq[1].push_back('{8'hA1, 1'b1});
        run_phase(100);

        chq[3].push_back('{8'h5A, 1'b1});
        run_phase(100);

        // random traffic with granted-channel stalls
        stall_en = 1;
        for (int p = 0; p < 8; p++) begin
            for (int c = 0; c < K; c++) begin
                int npk;
                npk = $urandom_range(0, 3);
                for (int k = 0; k < npk; k++) begin
                    int len;
                    len = $urandom_range(1, 10);
                    for (int i = 0; i < len; i++)
                        chq[c].push_back('{N'($urandom), i == len - 1});
                end
            end
            run_phase(4000);
        end
        stall_en = 0;

        // reset mid-word on channel 1
        mon_en = 0;
        bus.req_valid = 4'b0010;
        bus.req_last  = '0;
        bus.req_data[1*N +: N] = 8'h40;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.busy && n < 20);
        check("mid_word_granted", bus.busy, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_mid", bus.busy, 0);
        check("rst_ready_mid", bus.req_ready, 0);
        check("rst_valid_mid", bus.pk_valid_din, 0);
        check("rst_chan_mid", bus.pk_chan, 0);
        reset = 1'b0;
        bus.req_valid = '0;
        m_ptr = K - 1;
        load(3, 3, 8'h70, 1);
        load(1, 5, 8'h60, 1);
        run_phase(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
